// File: rtl/uart_rx_fifo_if.sv
// Receive-side stream handshake: head-of-FIFO data with its error tags,
// plus the consumer's accept strobe.
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_perr;
  logic       rx_ferr;

  modport master (output rx_data, output rx_valid, output rx_perr,
                  output rx_ferr, input rx_ready);
  modport slave  (input rx_data, input rx_valid, input rx_perr,
                  input rx_ferr, output rx_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// UART receiver with 16x oversampling, majority voting, optional parity,
// break handling and a small receive FIFO tagging each frame with its
// parity and framing error status.
module uart_rx_fifo #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             sysclk,
  input  logic             reset,
  input  logic             UART_RX,
  uart_rx_fifo_if.master   rx,
  output logic             overrun,
  input  logic             overrun_clr,
  output logic             busy
);

  localparam int DIV_RAW = (CLK_HZ + 8 * BAUD) / (16 * BAUD);
  localparam int DIV     = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam int CW      = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int EW      = DATA_BITS + 2;

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
  } state_t;

  state_t                 state_reg;
  logic                   sync1_reg, sync2_reg, line_prev_reg;
  logic [1:0]             sync_vld_reg;
  logic [CW-1:0]          tick_cnt_reg;
  logic [3:0]             phase_reg;
  logic [3:0]             bit_cnt_reg;
  logic                   s7_reg, s8_reg;
  logic [DATA_BITS-1:0]   shift_reg;
  logic                   perr_reg;
  logic                   busy_reg;
  logic                   overrun_reg;
  logic [AW:0]            wr_ptr_reg, rd_ptr_reg;
  logic [EW-1:0]          mem [FIFO_DEPTH];

  logic tick, fall, maj, par_exp, wr_en, full, empty, pop, accept;
  logic [EW-1:0] head_entry;
  logic [7:0]    data_ext;

  // Two-flop synchronizer; the valid shift marks when sync2 holds a real
  // line sample so a line already low at reset release is not an edge.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      sync1_reg     <= 1'b1;
      sync2_reg     <= 1'b1;
      sync_vld_reg  <= 2'b00;
      line_prev_reg <= 1'b0;
    end else begin
      sync1_reg     <= UART_RX;
      sync2_reg     <= sync1_reg;
      sync_vld_reg  <= {sync_vld_reg[0], 1'b1};
      line_prev_reg <= sync_vld_reg[1] ? sync2_reg : 1'b0;
    end
  end

  assign fall = line_prev_reg && !sync2_reg && sync_vld_reg[1];
  assign tick = (tick_cnt_reg == CW'(DIV - 1));

  // Oversampling tick divider, re-phased at each detected start edge.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      tick_cnt_reg <= '0;
    end else if ((state_reg == S_IDLE && fall) || tick) begin
      tick_cnt_reg <= '0;
    end else begin
      tick_cnt_reg <= tick_cnt_reg + CW'(1);
    end
  end

  assign maj     = (s7_reg & s8_reg) | (s7_reg & sync2_reg) | (s8_reg & sync2_reg);
  assign par_exp = (PARITY == 1) ? ~(^shift_reg) : (^shift_reg);

  // Frame decoder: walks start, data, optional parity and stop bits.
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      state_reg   <= S_IDLE;
      phase_reg   <= '0;
      bit_cnt_reg <= '0;
      s7_reg      <= 1'b1;
      s8_reg      <= 1'b1;
      shift_reg   <= '0;
      perr_reg    <= 1'b0;
      busy_reg    <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (fall) begin
            state_reg   <= S_START;
            phase_reg   <= '0;
            bit_cnt_reg <= '0;
            perr_reg    <= 1'b0;
            busy_reg    <= 1'b1;
          end
        end
        S_BREAK: begin
          if (sync2_reg) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end
        end
        default: begin
          if (tick) begin
            phase_reg <= phase_reg + 4'd1;
            if (phase_reg == 4'd7) s7_reg <= sync2_reg;
            if (phase_reg == 4'd8) s8_reg <= sync2_reg;
            case (state_reg)
              S_START: begin
                if (phase_reg == 4'd9 && maj) begin
                  state_reg <= S_IDLE;
                  busy_reg  <= 1'b0;
                end else if (phase_reg == 4'd15) begin
                  state_reg <= S_DATA;
                end
              end
              S_DATA: begin
                if (phase_reg == 4'd9) begin
                  if (DATA_BITS > 1) shift_reg <= {maj, shift_reg[DATA_BITS-1:1]};
                  else               shift_reg <= maj;
                  bit_cnt_reg <= bit_cnt_reg + 4'd1;
                end
                if (phase_reg == 4'd15 && bit_cnt_reg == 4'(DATA_BITS))
                  state_reg <= (PARITY != 0) ? S_PARITY : S_STOP;
              end
              S_PARITY: begin
                if (phase_reg == 4'd9)  perr_reg  <= maj ^ par_exp;
                if (phase_reg == 4'd15) state_reg <= S_STOP;
              end
              S_STOP: begin
                if (phase_reg == 4'd9) begin
                  state_reg <= maj ? S_IDLE : S_BREAK;
                  busy_reg  <= ~maj;
                end
              end
              default: ;
            endcase
          end
        end
      endcase
    end
  end

  assign wr_en  = (state_reg == S_STOP) && tick && (phase_reg == 4'd9);
  assign empty  = (wr_ptr_reg == rd_ptr_reg);
  assign full   = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                  (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign pop    = !empty && rx.rx_ready;
  assign accept = wr_en && (!full || pop);

  // FIFO storage; a pop in the same cycle frees the slot being written.
  always_ff @(posedge sysclk) begin
    if (accept) mem[wr_ptr_reg[AW-1:0]] <= {~maj, perr_reg, shift_reg};
  end

  // FIFO pointers and sticky overrun flag (set dominates clear).
  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      overrun_reg <= 1'b0;
    end else begin
      if (accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)    rd_ptr_reg <= rd_ptr_reg + 1'b1;
      if (wr_en && full && !pop) overrun_reg <= 1'b1;
      else if (overrun_clr)      overrun_reg <= 1'b0;
    end
  end

  assign head_entry = mem[rd_ptr_reg[AW-1:0]];

  for (genvar gi = 0; gi < 8; gi++) begin : g_ext
    if (gi < DATA_BITS) begin : g_bit
      assign data_ext[gi] = head_entry[gi];
    end else begin : g_zero
      assign data_ext[gi] = 1'b0;
    end
  end

  assign rx.rx_valid = !empty;
  assign rx.rx_data  = empty ? 8'h00 : data_ext;
  assign rx.rx_perr  = !empty && head_entry[DATA_BITS];
  assign rx.rx_ferr  = !empty && head_entry[DATA_BITS+1];
  assign overrun     = overrun_reg;
  assign busy        = busy_reg;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench: four receiver instances cover no-parity, even parity,
// a two-entry FIFO, and five data bits with reset applied mid-frame.
module tb_uart_rx_fifo;

  logic clk;
  logic reset, reset_d;
  logic line [4];
  logic ovr_clr;
  logic busy_a, busy_b, busy_c, busy_d;
  logic ovr_a, ovr_b, ovr_c, ovr_d;
  int   tests = 0;
  int   fails = 0;

  uart_rx_fifo_if if_a();
  uart_rx_fifo_if if_b();
  uart_rx_fifo_if if_c();
  uart_rx_fifo_if if_d();

  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(4))
    dut_a (.sysclk(clk), .reset(reset), .UART_RX(line[0]), .rx(if_a),
           .overrun(ovr_a), .overrun_clr(ovr_clr), .busy(busy_a));
  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4))
    dut_b (.sysclk(clk), .reset(reset), .UART_RX(line[1]), .rx(if_b),
           .overrun(ovr_b), .overrun_clr(ovr_clr), .busy(busy_b));
  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(0), .FIFO_DEPTH(2))
    dut_c (.sysclk(clk), .reset(reset), .UART_RX(line[2]), .rx(if_c),
           .overrun(ovr_c), .overrun_clr(ovr_clr), .busy(busy_c));
  uart_rx_fifo #(.CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(5), .PARITY(0), .FIFO_DEPTH(4))
    dut_d (.sysclk(clk), .reset(reset_d), .UART_RX(line[3]), .rx(if_d),
           .overrun(ovr_d), .overrun_clr(ovr_clr), .busy(busy_d));

  // Free-running clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang.
  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish, observed running required finished");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive_bit(input int u, input logic b);
    line[u] = b;
    wait_cycles(16);
  endtask

  // Start bit, LSB-first data, optional parity bit (pbit < 0: none), stop bit.
  // The stop level is left on the line afterwards.
  task automatic send_frame(input int u, input logic [7:0] d, input int nbits,
                            input int pbit, input logic stop_b);
    drive_bit(u, 1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(u, d[i]);
    if (pbit >= 0) drive_bit(u, pbit[0]);
    drive_bit(u, stop_b);
  endtask

  task automatic pulse_ready(input int u);
    case (u)
      0: if_a.rx_ready = 1'b1;
      1: if_b.rx_ready = 1'b1;
      2: if_c.rx_ready = 1'b1;
      default: if_d.rx_ready = 1'b1;
    endcase
    wait_cycles(1);
    if_a.rx_ready = 1'b0;
    if_b.rx_ready = 1'b0;
    if_c.rx_ready = 1'b0;
    if_d.rx_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 4; i++) line[i] = 1'b1;
    if_a.rx_ready = 1'b0;
    if_b.rx_ready = 1'b0;
    if_c.rx_ready = 1'b0;
    if_d.rx_ready = 1'b0;
    ovr_clr = 1'b0;
    reset   = 1'b1;
    reset_d = 1'b1;
    #2;
    reset   = 1'b0;
    reset_d = 1'b0;
    wait_cycles(3);

    // Reset state
    check("rst_valid", if_a.rx_valid, 0);
    check("rst_data",  if_a.rx_data, 8'h00);
    check("rst_busy",  busy_a, 0);
    check("rst_ovr",   ovr_c, 0);
    check("rst_ferr",  if_a.rx_ferr, 0);
    reset   = 1'b1;
    reset_d = 1'b1;
    wait_cycles(5);

    // 0x55, no parity, held without pop
    send_frame(0, 8'h55, 8, -1, 1'b1);
    wait_cycles(4);
    check("a55_valid", if_a.rx_valid, 1);
    check("a55_data",  if_a.rx_data, 8'h55);
    check("a55_perr",  if_a.rx_perr, 0);
    check("a55_ferr",  if_a.rx_ferr, 0);
    wait_cycles(20);
    check("a55_hold_data",  if_a.rx_data, 8'h55);
    check("a55_hold_valid", if_a.rx_valid, 1);
    pulse_ready(0);
    check("a55_popped", if_a.rx_valid, 0);

    // Short glitch is a false start
    line[0] = 1'b0;
    wait_cycles(5);
    check("glitch_busy", busy_a, 1);
    line[0] = 1'b1;
    wait_cycles(30);
    check("glitch_idle",  busy_a, 0);
    check("glitch_valid", if_a.rx_valid, 0);

    // 0x0F with a low stop bit, line held low for 40 cycles
    send_frame(0, 8'h0F, 8, -1, 1'b0);
    wait_cycles(24);
    check("brk_valid", if_a.rx_valid, 1);
    check("brk_data",  if_a.rx_data, 8'h0F);
    check("brk_ferr",  if_a.rx_ferr, 1);
    check("brk_perr",  if_a.rx_perr, 0);
    check("brk_busy",  busy_a, 1);
    line[0] = 1'b1;
    wait_cycles(5);
    check("brk_exit", busy_a, 0);
    pulse_ready(0);
    check("brk_popped", if_a.rx_valid, 0);

    // Even parity: 0xA3 has four ones, so parity bit 1 is wrong, 0 is right
    send_frame(1, 8'hA3, 8, 1, 1'b1);
    wait_cycles(4);
    check("par1_data", if_b.rx_data, 8'hA3);
    check("par1_perr", if_b.rx_perr, 1);
    check("par1_ferr", if_b.rx_ferr, 0);
    pulse_ready(1);
    send_frame(1, 8'hA3, 8, 0, 1'b1);
    wait_cycles(4);
    check("par0_data", if_b.rx_data, 8'hA3);
    check("par0_perr", if_b.rx_perr, 0);
    pulse_ready(1);
    check("par_popped", if_b.rx_valid, 0);

    // Two-entry FIFO overrun
    send_frame(2, 8'h11, 8, -1, 1'b1);
    wait_cycles(2);
    send_frame(2, 8'h22, 8, -1, 1'b1);
    wait_cycles(2);
    check("ovr_before", ovr_c, 0);
    send_frame(2, 8'h33, 8, -1, 1'b1);
    wait_cycles(2);
    check("ovr_set",   ovr_c, 1);
    check("ovr_head0", if_c.rx_data, 8'h11);
    pulse_ready(2);
    check("ovr_head1", if_c.rx_data, 8'h22);
    pulse_ready(2);
    check("ovr_empty", if_c.rx_valid, 0);
    check("ovr_sticky", ovr_c, 1);
    ovr_clr = 1'b1;
    wait_cycles(1);
    ovr_clr = 1'b0;
    check("ovr_clr", ovr_c, 0);

    // Five data bits, then reset in the middle of a second frame
    send_frame(3, 8'h1F, 5, -1, 1'b1);
    wait_cycles(4);
    check("d5_valid", if_d.rx_valid, 1);
    check("d5_data",  if_d.rx_data, 8'h1F);
    line[3] = 1'b0;
    wait_cycles(20);
    check("d5_mid_busy", busy_d, 1);
    reset_d = 1'b0;
    #1;
    check("d5_rst_valid", if_d.rx_valid, 0);
    check("d5_rst_busy",  busy_d, 0);
    check("d5_rst_data",  if_d.rx_data, 8'h00);
    wait_cycles(3);
    reset_d = 1'b1;
    wait_cycles(30);
    check("d5_low_nostart", busy_d, 0);
    check("d5_low_valid",   if_d.rx_valid, 0);
    line[3] = 1'b1;
    wait_cycles(10);
    send_frame(3, 8'h0A, 5, -1, 1'b1);
    wait_cycles(4);
    check("d5_after_data",  if_d.rx_data, 8'h0A);
    check("d5_after_valid", if_d.rx_valid, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
